matbi_watch_fnd_driver: RTL

Display-side consumer of the watch time outputs. It takes the binary hour/minute/second values and drives a 6-digit multiplexed seven-segment (FND) display. Each frame it snapshots the time, converts it to BCD with serial shift-add-3 converters, and scans the digits at a programmable rate. It sits between the watch core outputs and the board FND pins.

---
 rtl/matbi_watch_fnd_driver_pkg.sv | 45 ++++
 rtl/matbi_watch_fnd_driver_bin2bcd6.sv | 53 +++++
 rtl/matbi_watch_fnd_driver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/matbi_watch_fnd_driver_pkg.sv
// Shared definitions for the watch FND driver: segment codes, conversion FSM states
// and the digit-encoding helper.
package matbi_watch_fnd_driver_pkg;

    localparam int LP_NUM_DIGITS = 6;
    localparam int LP_BIN_W      = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CONV,
        ST_LOAD
    } conv_state_t;

    function automatic logic [7:0] segEncode(input logic [3:0] value);
        logic [7:0] code;
        case (value)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/matbi_watch_fnd_driver_bin2bcd6.sv
// Serial shift-add-3 converter: 6-bit binary to tens/ones BCD in six shift cycles.
module matbi_bin2bcd6
    import matbi_watch_fnd_driver_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [LP_BIN_W-1:0] i_bin,
    output logic                o_done,
    output logic [2:0]          o_tens,
    output logic [3:0]          o_ones
);

    logic [2:0]          r_tens;
    logic [3:0]          r_ones;
    logic [LP_BIN_W-1:0] r_bin;
    logic [2:0]          r_cnt;
    logic                r_busy;
    logic [3:0]          w_onesAdj;
    logic                w_shiftDone;

    // Tens never reaches 5 before a shift for a 6-bit input, so only ones needs the add-3 step.
    assign w_onesAdj   = (r_ones >= 4'd5) ? (r_ones + 4'd3) : r_ones;
    assign w_shiftDone = (r_cnt == 3'(LP_BIN_W));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tens <= '0;
            r_ones <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_tens <= '0;
            r_ones <= '0;
            r_bin  <= i_bin;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_shiftDone) begin
                r_busy <= 1'b0;
            end else begin
                {r_tens, r_ones, r_bin} <= {r_tens[1:0], w_onesAdj, r_bin, 1'b0};
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign o_done = r_busy && w_shiftDone;
    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule

// File: rtl/matbi_watch_fnd_driver.sv
// Six-digit multiplexed FND driver for the watch time outputs.
// Optional macro MATBI_WATCH_COLON_BLINK_EN blinks the separator dots with the seconds LSB.
module matbi_watch_fnd_driver
    import matbi_watch_fnd_driver_pkg::*;
#(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5,
    parameter int P_SCAN_DIV = 100000
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run_en,
    input  logic [P_SEC_BIT-1:0]  i_sec,
    input  logic [P_MIN_BIT-1:0]  i_min,
    input  logic [P_HOUR_BIT-1:0] i_hour,
    output logic [5:0]            o_fnd_sel,
    output logic [7:0]            o_fnd_seg
);

    localparam int                  LP_CNT_W   = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [LP_CNT_W-1:0] LP_SCAN_TC = LP_CNT_W'(P_SCAN_DIV - 1);

    logic [LP_CNT_W-1:0] r_scanCnt;
    logic [2:0]          r_digit;
    logic                w_scanTick;
    logic                w_frameStart;
    conv_state_t         r_state;
    conv_state_t         w_stateNext;
    logic                r_pending;
    logic                w_beginConv;
    logic                w_convStart;
    logic                w_convDone;
    logic [5:0]          r_secSnap;
    logic [5:0]          r_minSnap;
    logic [5:0]          r_hourSnap;
    logic                w_secDone;
    logic                w_minDone;
    logic                w_hourDone;
    logic [2:0]          w_secTens;
    logic [2:0]          w_minTens;
    logic [2:0]          w_hourTens;
    logic [3:0]          w_secOnes;
    logic [3:0]          w_minOnes;
    logic [3:0]          w_hourOnes;
    logic [2:0]          r_dispSecTens;
    logic [2:0]          r_dispMinTens;
    logic [2:0]          r_dispHourTens;
    logic [3:0]          r_dispSecOnes;
    logic [3:0]          r_dispMinOnes;
    logic [3:0]          r_dispHourOnes;
    logic [3:0]          w_digitValue;
    logic                w_isSep;
    logic                w_dpLit;
    logic [7:0]          w_segCode;
    logic [5:0]          r_fndSel;
    logic [7:0]          r_fndSeg;

    assign w_scanTick   = i_run_en && (r_scanCnt == LP_SCAN_TC);
    assign w_frameStart = w_scanTick && (r_digit == 3'(LP_NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scanCnt <= '0;
            r_digit   <= '0;
        end else if (i_run_en) begin
            if (w_scanTick) begin
                r_scanCnt <= '0;
                r_digit   <= w_frameStart ? 3'd0 : (r_digit + 3'd1);
            end else begin
                r_scanCnt <= r_scanCnt + 1'b1;
            end
        end
    end

    assign w_beginConv = (r_state == ST_IDLE) && (r_pending || w_frameStart);
    assign w_convStart = (r_state == ST_CAPTURE);
    assign w_convDone  = w_secDone && w_minDone && w_hourDone;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:    if (r_pending || w_frameStart) w_stateNext = ST_CAPTURE;
            ST_CAPTURE: w_stateNext = ST_CONV;
            ST_CONV:    if (w_convDone) w_stateNext = ST_LOAD;
            ST_LOAD:    w_stateNext = ST_IDLE;
            default:    w_stateNext = ST_IDLE;
        endcase
    end

    // Pending starts set so the first frame after reset is converted without waiting a full scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending  <= 1'b1;
            r_secSnap  <= '0;
            r_minSnap  <= '0;
            r_hourSnap <= '0;
        end else begin
            if (r_state == ST_IDLE)  r_pending <= 1'b0;
            else if (w_frameStart)   r_pending <= 1'b1;
            if (w_beginConv) begin
                r_secSnap  <= 6'(i_sec);
                r_minSnap  <= 6'(i_min);
                r_hourSnap <= 6'(i_hour);
            end
        end
    end

    matbi_bin2bcd6 u_secConv  (.clk(clk), .reset(reset), .i_start(w_convStart), .i_bin(r_secSnap),
                               .o_done(w_secDone), .o_tens(w_secTens), .o_ones(w_secOnes));
    matbi_bin2bcd6 u_minConv  (.clk(clk), .reset(reset), .i_start(w_convStart), .i_bin(r_minSnap),
                               .o_done(w_minDone), .o_tens(w_minTens), .o_ones(w_minOnes));
    matbi_bin2bcd6 u_hourConv (.clk(clk), .reset(reset), .i_start(w_convStart), .i_bin(r_hourSnap),
                               .o_done(w_hourDone), .o_tens(w_hourTens), .o_ones(w_hourOnes));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dispSecTens  <= '0;
            r_dispSecOnes  <= '0;
            r_dispMinTens  <= '0;
            r_dispMinOnes  <= '0;
            r_dispHourTens <= '0;
            r_dispHourOnes <= '0;
        end else if ((r_state == ST_CONV) && w_convDone) begin
            r_dispSecTens  <= w_secTens;
            r_dispSecOnes  <= w_secOnes;
            r_dispMinTens  <= w_minTens;
            r_dispMinOnes  <= w_minOnes;
            r_dispHourTens <= w_hourTens;
            r_dispHourOnes <= w_hourOnes;
        end
    end

`ifdef MATBI_WATCH_COLON_BLINK_EN
    logic r_dispSecLsb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                r_dispSecLsb <= 1'b0;
        else if ((r_state == ST_CONV) && w_convDone) r_dispSecLsb <= r_secSnap[0];
    end

    assign w_dpLit = !r_dispSecLsb;
`else
    assign w_dpLit = 1'b1;
`endif

    always_comb begin
        w_digitValue = 4'd0;
        case (r_digit)
            3'd0:    w_digitValue = r_dispSecOnes;
            3'd1:    w_digitValue = {1'b0, r_dispSecTens};
            3'd2:    w_digitValue = r_dispMinOnes;
            3'd3:    w_digitValue = {1'b0, r_dispMinTens};
            3'd4:    w_digitValue = r_dispHourOnes;
            3'd5:    w_digitValue = {1'b0, r_dispHourTens};
            default: w_digitValue = 4'hF;
        endcase
    end

    assign w_isSep   = (r_digit == 3'd2) || (r_digit == 3'd4);
    assign w_segCode = segEncode(w_digitValue);

    // Outputs freeze with the scan so the board never sees a half-updated digit while halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fndSel <= 6'b111110;
            r_fndSeg <= SEG_0;
        end else if (i_run_en) begin
            r_fndSel <= ~(6'd1 << r_digit);
            r_fndSeg <= {w_segCode[7] & ~(w_isSep & w_dpLit), w_segCode[6:0]};
        end
    end

    assign o_fnd_sel = r_fndSel;
    assign o_fnd_seg = r_fndSeg;

endmodule
